// File: rtl/sfp_ctrl_pkg.sv
// Shared types and constants for the sfp_row controller: state encoding and row sizing.
package sfp_ctrl_pkg;

  localparam int unsigned ROW_W_DEF = 4;
  localparam int unsigned MAX_ROWS  = 1 << ROW_W_DEF;
  localparam int unsigned STATE_W   = 3;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE  = 3'd0,
    S_ACC   = 3'd1,
    S_SYNC  = 3'd2,
    S_DIV   = 3'd3,
    S_DRAIN = 3'd4,
    S_DONE  = 3'd5
  } state_e;

  // States in which our acc pass is complete and the peer may rely on our sums
  function automatic logic is_post_acc(state_e s);
    return (s == S_SYNC) || (s == S_DIV) || (s == S_DRAIN);
  endfunction

endpackage

// File: rtl/sfp_row_ctrl_cnt.sv
// Row counter shared by the acc and div passes: clear, enable and last-row compare.
module sfp_row_ctrl_cnt
  import sfp_ctrl_pkg::*;
#(
  parameter int unsigned W = ROW_W_DEF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         en,
  input  logic [W:0]   limit,
  output logic [W-1:0] cnt,
  output logic         last_c
);

  logic [W-1:0] cnt_d;
  logic [W-1:0] cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt    = cnt_q;
  // A full 2**W job ends at all-ones, hence the extra limit bit
  assign last_c = ({1'b0, cnt_q} == (limit - (W+1)'(1)));

endmodule

// File: rtl/sfp_row_ctrl.sv
// Initiator-side sequencer for one core's sfp_row: acc pass, peer sync, div pass.
// Optional stall counter enabled by defining SFP_ROW_CTRL_PERF_EN.
module sfp_row_ctrl
  import sfp_ctrl_pkg::*;
#(
  parameter int unsigned ROW_W  = ROW_W_DEF,
  parameter int unsigned PERF_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ROW_W:0]    num_rows,
  input  logic              row_valid,
  output logic [ROW_W-1:0]  row_addr,
  output logic              acc,
  output logic              div,
  output logic              peer_ext_rd,
  output logic              out_wr,
  output logic [ROW_W-1:0]  out_addr,
  output logic              local_done,
  input  logic              peer_done,
  output logic              busy,
  output logic              done,
  output logic [PERF_W-1:0] perf_stall_cnt
);

  localparam logic [ROW_W:0] ROWS_MAX = (ROW_W+1)'(1 << ROW_W);

  state_e state_q;
  state_e state_d;

  logic [ROW_W:0]   rows_q;
  logic [ROW_W:0]   rows_d;
  logic [ROW_W:0]   rows_clip_c;
  logic             start_ok_c;
  logic             acc_c;
  logic             div_c;
  logic             last_c;
  logic             cnt_clr_c;
  logic             cnt_en_c;
  logic [ROW_W-1:0] cnt;

  logic             peer_ext_rd_q, peer_ext_rd_d;
  logic             out_wr_q, out_wr_d;
  logic [ROW_W-1:0] out_addr_q, out_addr_d;
  logic             local_done_q, local_done_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  assign rows_clip_c = (num_rows > ROWS_MAX) ? ROWS_MAX : num_rows;
  assign start_ok_c  = start && (state_q == S_IDLE);

  // Next state, pass strobes and next values of the registered outputs
  always_comb begin
    state_d       = state_q;
    rows_d        = rows_q;
    acc_c         = 1'b0;
    div_c         = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          rows_d  = rows_clip_c;
          state_d = (rows_clip_c == '0) ? S_DONE : S_ACC;
        end
      end
      S_ACC: begin
        acc_c = row_valid;
        if (row_valid && last_c) state_d = S_SYNC;
      end
      S_SYNC: begin
        if (peer_done) state_d = S_DIV;
      end
      S_DIV: begin
        div_c = row_valid;
        if (row_valid && last_c) state_d = S_DRAIN;
      end
      S_DRAIN: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // sfp_row pops the peer sum and presents sfp_out one cycle after each div
    peer_ext_rd_d = div_c;
    out_wr_d      = div_c;
    out_addr_d    = div_c ? cnt : '0;
    busy_d        = (state_d != S_IDLE);
    done_d        = (state_d == S_DONE);
    // An empty job never announces sums to the peer
    local_done_d  = is_post_acc(state_d) ||
                    ((state_d == S_DONE) && (state_q == S_DRAIN));
  end

  assign cnt_clr_c = start_ok_c || ((acc_c || div_c) && last_c);
  assign cnt_en_c  = acc_c || div_c;

  sfp_row_ctrl_cnt #(
    .W (ROW_W)
  ) u_cnt (
    .clk    (clk),
    .reset  (reset),
    .clr    (cnt_clr_c),
    .en     (cnt_en_c),
    .limit  (rows_q),
    .cnt    (cnt),
    .last_c (last_c)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      rows_q        <= '0;
      peer_ext_rd_q <= 1'b0;
      out_wr_q      <= 1'b0;
      out_addr_q    <= '0;
      local_done_q  <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      rows_q        <= rows_d;
      peer_ext_rd_q <= peer_ext_rd_d;
      out_wr_q      <= out_wr_d;
      out_addr_q    <= out_addr_d;
      local_done_q  <= local_done_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  assign row_addr    = cnt;
  assign acc         = acc_c;
  assign div         = div_c;
  assign peer_ext_rd = peer_ext_rd_q;
  assign out_wr      = out_wr_q;
  assign out_addr    = out_addr_q;
  assign local_done  = local_done_q;
  assign busy        = busy_q;
  assign done        = done_q;

`ifdef SFP_ROW_CTRL_PERF_EN
  logic [PERF_W-1:0] perf_q;
  logic [PERF_W-1:0] perf_d;
  logic              stall_c;

  // Stall = waiting on the peer, or a pass cycle with no row presented
  always_comb begin
    stall_c = (state_q == S_SYNC) ||
              (((state_q == S_ACC) || (state_q == S_DIV)) && !row_valid);
    perf_d  = perf_q;
    if (start_ok_c) begin
      perf_d = '0;
    end else if (stall_c && (perf_q != '1)) begin
      perf_d = perf_q + PERF_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_q <= '0;
    end else begin
      perf_q <= perf_d;
    end
  end

  assign perf_stall_cnt = perf_q;
`else
  assign perf_stall_cnt = '0;
`endif

endmodule
